// File: rtl/id_stage.sv
// RV32I decode stage with an ID/EX pipeline register and valid/ready handshakes on both sides.
// Optional writeback bypass into the operand capture is enabled by defining ID_WB_BYPASS_EN.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int RV32E = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            wb_wen_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic            illegal_o
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd_f, rs1_f, rs2_f;

  assign opc   = inst_i[6:0];
  assign rd_f  = inst_i[11:7];
  assign f3    = inst_i[14:12];
  assign rs1_f = inst_i[19:15];
  assign rs2_f = inst_i[24:20];
  assign f7    = inst_i[31:25];

  logic signed [11:0] imm_i_s;
  logic signed [12:0] imm_b_s;
  logic signed [31:0] imm_u_s;
  logic signed [20:0] imm_j_s;
  logic [XLEN-1:0]    imm_i, imm_b, imm_u, imm_j;

  assign imm_i_s = inst_i[31:20];
  assign imm_b_s = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_s = {inst_i[31:12], 12'b0};
  assign imm_j_s = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_i   = XLEN'(imm_i_s);
  assign imm_b   = XLEN'(imm_b_s);
  assign imm_u   = XLEN'(imm_u_s);
  assign imm_j   = XLEN'(imm_j_s);

  // Operand values as read this cycle; x0 is forced to zero ahead of any bypass.
  logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ID_WB_BYPASS_EN
  always_comb begin
    rs1_val = rs1_data_i;
    rs2_val = rs2_data_i;
    if (wb_wen_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs1_f)) rs1_val = wb_data_i;
    if (wb_wen_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs2_f)) rs2_val = wb_data_i;
    if (rs1_f == 5'd0) rs1_val = '0;
    if (rs2_f == 5'd0) rs2_val = '0;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wen_i, wb_addr_i, wb_data_i};

  always_comb begin
    rs1_val = (rs1_f == 5'd0) ? '0 : rs1_data_i;
    rs2_val = (rs2_f == 5'd0) ? '0 : rs2_data_i;
  end
`endif

  logic            legal, use_rs1, use_rs2, writes_rd;
  logic [XLEN-1:0] op1_d, op2_d, imm_d;
  logic [4:0]      rd_d;
  logic            wen_d;

  always_comb begin
    legal     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    op1_d     = '0;
    op2_d     = '0;
    imm_d     = '0;
    case (opc)
      7'h13: begin
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 legal = 1'b1;
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        op1_d     = rs1_val;
        op2_d     = imm_i;
        imm_d     = imm_i;
      end
      7'h33: begin
        legal     = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
        op1_d     = rs1_val;
        op2_d     = rs2_val;
      end
      7'h63: begin
        legal   = (f3 != 3'd2) && (f3 != 3'd3);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        op1_d   = rs1_val;
        op2_d   = rs2_val;
        imm_d   = imm_b;
      end
      7'h37: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        op2_d     = imm_u;
        imm_d     = imm_u;
      end
      7'h17: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        op1_d     = inst_addr_i;
        op2_d     = imm_u;
        imm_d     = imm_u;
      end
      7'h6F: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        op1_d     = inst_addr_i;
        op2_d     = XLEN'(4);
        imm_d     = imm_j;
      end
      default: legal = 1'b0;
    endcase

    if ((RV32E != 0) && ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (writes_rd && rd_f[4])))
      legal = 1'b0;

    rd_d  = writes_rd ? rd_f : 5'd0;
    wen_d = writes_rd && (rd_f != 5'd0);

    if (!legal) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      op1_d   = '0;
      op2_d   = '0;
      imm_d   = '0;
      rd_d    = 5'd0;
      wen_d   = 1'b0;
    end
  end

  assign rs1_addr_o = use_rs1 ? rs1_f : 5'd0;
  assign rs2_addr_o = use_rs2 ? rs2_f : 5'd0;

  logic            valid_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] addr_q, op1_q, op2_q, imm_q;
  logic [4:0]      rd_q;
  logic            wen_q, ill_q;
  logic            capture;

  assign in_ready_o = !valid_q || out_ready_i;
  assign capture    = in_valid_i && in_ready_o;

  // Flush outranks capture and hold; data registers are left alone since valid gates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      addr_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      inst_q  <= inst_i;
      addr_q  <= inst_addr_i;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      ill_q   <= !legal;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign imm_o       = imm_q;
  assign rd_addr_o   = rd_q;
  assign reg_wen_o   = wen_q;
  assign illegal_o   = ill_q;

endmodule
